// File: rtl/prog_loader.sv
// prog_loader: writes a program into instruction memory from a byte stream.
// A frame is SYNC, length L, L instruction bytes, then an 8-bit additive checksum.
// CPU execution (o_cpu_run) is enabled only after a frame whose checksum matches.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_in_valid   i_in_data holds a byte
//   i_in_data    stream byte
//   o_in_ready   always 1; a byte transfers whenever i_in_valid is high
//   o_wr_en      one-cycle instruction-memory write strobe
//   o_wr_addr    write address (holds when o_wr_en is low)
//   o_wr_data    write data (holds when o_wr_en is low)
//   o_cpu_run    CPU may execute
//   o_load_done  sticky: last frame loaded with a good checksum
//   o_load_err   sticky: last frame aborted (length, checksum or timeout)
//   o_busy       frame in progress
module prog_loader #(
    parameter int          DEPTH   = 16,
    parameter int          AW      = 4,
    parameter int          TIMEOUT = 255,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_in_valid,
    input  logic [7:0]    i_in_data,
    output logic          o_in_ready,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic          o_cpu_run,
    output logic          o_load_done,
    output logic          o_load_err,
    output logic          o_busy
);
    // Count/length need one extra bit so a full DEPTH-word program fits.
    localparam int         CW     = AW + 1;
    localparam int         TW     = $clog2(TIMEOUT + 1);
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_SUM} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_len, w_len_nx;
    logic [CW-1:0] r_count, w_count_nx, w_count_inc;
    logic [7:0]    r_sum, w_sum_nx;
    logic [TW-1:0] r_timer, w_timer_nx;
    logic          r_wr_en, w_wr_en_nx;
    logic [AW-1:0] r_wr_addr, w_wr_addr_nx;
    logic [7:0]    r_wr_data, w_wr_data_nx;
    logic          r_cpu_run, w_cpu_run_nx;
    logic          r_done, w_done_nx;
    logic          r_err, w_err_nx;
    logic          w_acc;

    assign w_acc       = i_in_valid;  // ready is permanently high
    assign w_count_inc = r_count + CW'(1);

    always_comb begin
        w_state_nx   = r_state;
        w_len_nx     = r_len;
        w_count_nx   = r_count;
        w_sum_nx     = r_sum;
        w_timer_nx   = '0;
        w_wr_en_nx   = 1'b0;
        w_wr_addr_nx = r_wr_addr;
        w_wr_data_nx = r_wr_data;
        w_cpu_run_nx = r_cpu_run;
        w_done_nx    = r_done;
        w_err_nx     = r_err;

        case (r_state)
            S_IDLE: begin
                if (w_acc && i_in_data == SYNC) begin
                    w_state_nx   = S_LEN;
                    w_cpu_run_nx = 1'b0;
                    w_done_nx    = 1'b0;
                    w_err_nx     = 1'b0;
                end
            end
            S_LEN: begin
                if (w_acc) begin
                    if (i_in_data == 8'd0 || i_in_data > DEPTH8) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_len_nx   = i_in_data[CW-1:0];
                        w_count_nx = '0;
                        w_sum_nx   = '0;
                        w_state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // SYNC-valued bytes are plain data here; no mid-frame resync.
                if (w_acc) begin
                    w_wr_en_nx   = 1'b1;
                    w_wr_addr_nx = r_count[AW-1:0];
                    w_wr_data_nx = i_in_data;
                    w_sum_nx     = r_sum + i_in_data;
                    w_count_nx   = w_count_inc;
                    if (w_count_inc == r_len)
                        w_state_nx = S_SUM;
                end
            end
            S_SUM: begin
                if (w_acc) begin
                    if (i_in_data == r_sum) begin
                        w_done_nx    = 1'b1;
                        w_cpu_run_nx = 1'b1;
                    end else begin
                        w_err_nx     = 1'b1;
                    end
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Inter-byte timeout: abort on the edge where the idle count reaches
        // TIMEOUT, i.e. after TIMEOUT consecutive cycles without a byte.
        if (r_state != S_IDLE && !w_acc) begin
            if (r_timer == TLAST) begin
                w_state_nx = S_IDLE;
                w_err_nx   = 1'b1;
            end else begin
                w_timer_nx = r_timer + TW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_count   <= '0;
            r_sum     <= '0;
            r_timer   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_cpu_run <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_len     <= w_len_nx;
            r_count   <= w_count_nx;
            r_sum     <= w_sum_nx;
            r_timer   <= w_timer_nx;
            r_wr_en   <= w_wr_en_nx;
            r_wr_addr <= w_wr_addr_nx;
            r_wr_data <= w_wr_data_nx;
            r_cpu_run <= w_cpu_run_nx;
            r_done    <= w_done_nx;
            r_err     <= w_err_nx;
        end
    end

    assign o_in_ready  = 1'b1;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_cpu_run   = r_cpu_run;
    assign o_load_done = r_done;
    assign o_load_err  = r_err;
    assign o_busy      = (r_state != S_IDLE);
endmodule
